// File: rtl/reg_file_32x32.sv
// 32x32 MIPS general-purpose register file: two combinational read ports, one
// clocked write port, r0 hard-wired to zero, optional write-through bypass.
module reg_file_32x32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int DEPTH = 2 ** ADDR_W;

    // r0 has no storage; the array starts at index 1.
    logic [DATA_W-1:0] regs_q [1:DEPTH-1];
    logic [DATA_W-1:0] regs_d [1:DEPTH-1];

    always_comb begin
        for (int i = 1; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we && (wa != '0)) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Bypass is gated by rst_n so every address reads zero during reset.
    always_comb begin
        rd1 = '0;
        if (ra1 != '0) begin
            rd1 = (BYPASS && rst_n && we && (wa == ra1)) ? wd : regs_q[ra1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != '0) begin
            rd2 = (BYPASS && rst_n && we && (wa == ra2)) ? wd : regs_q[ra2];
        end
    end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed bench for reg_file_32x32: a bypass and a non-bypass instance share
// stimulus; expected read data is queued by the driver and checked by a monitor.
module tb_reg_file_32x32;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int EXP_W  = 4 * DATA_W;

    logic              clk;
    logic              rst_n;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1_b, rd2_b;
    logic [DATA_W-1:0] rd1_n, rd2_n;

    logic [EXP_W-1:0] exp_q[$];
    string            name_q[$];
    event             mon_ev;
    int               checks;
    int               failures;

    reg_file_32x32 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b1)) u_dut_byp (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b)
    );

    reg_file_32x32 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_dut_nob (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change on the falling edge, far from the rising edge.
    task automatic drive(input logic w_en, input logic [ADDR_W-1:0] w_a,
                         input logic [DATA_W-1:0] w_d,
                         input logic [ADDR_W-1:0] r_a1, input logic [ADDR_W-1:0] r_a2);
        we  = w_en;
        wa  = w_a;
        wd  = w_d;
        ra1 = r_a1;
        ra2 = r_a2;
    endtask

    task automatic expect_rd(input string name,
                             input logic [DATA_W-1:0] e1_b, input logic [DATA_W-1:0] e2_b,
                             input logic [DATA_W-1:0] e1_n, input logic [DATA_W-1:0] e2_n);
        #1;
        exp_q.push_back({e1_b, e2_b, e1_n, e2_n});
        name_q.push_back(name);
        -> mon_ev;
        #1;
    endtask

    function automatic logic [DATA_W-1:0] pat(input int i);
        return (i == 0) ? '0 : (32'h1000_0000 + DATA_W'(i));
    endfunction

    // Scoreboard monitor
    task automatic cmp(input string name, input string port,
                       input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s %s: got 0x%08h expected 0x%08h", name, port, act, exp);
        end
    endtask

    always @(mon_ev) begin
        logic [EXP_W-1:0] e;
        string n;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL monitor_underflow: got empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            cmp(n, "rd1_bypass",   rd1_b, e[4*DATA_W-1:3*DATA_W]);
            cmp(n, "rd2_bypass",   rd2_b, e[3*DATA_W-1:2*DATA_W]);
            cmp(n, "rd1_nobypass", rd1_n, e[2*DATA_W-1:DATA_W]);
            cmp(n, "rd2_nobypass", rd2_n, e[DATA_W-1:0]);
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);

        // Reset state, including a suppressed bypass while rst_n is low
        @(negedge clk);
        expect_rd("reset_state", 32'h0, 32'h0, 32'h0, 32'h0);
        drive(1'b1, 5'd5, 32'h5555_5555, 5'd5, 5'd5);
        expect_rd("reset_no_bypass", 32'h0, 32'h0, 32'h0, 32'h0);

        // Release and preload r5
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
        expect_rd("r5_write_same_cycle", 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        expect_rd("r5_after_edge", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Asynchronous reset between edges, with a write pending
        @(negedge clk);
        rst_n = 1'b0;
        expect_rd("async_reset_clears", 32'h0, 32'h0, 32'h0, 32'h0);
        drive(1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd5);
        expect_rd("reset_pending_write", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        expect_rd("after_release", 32'h0, 32'h0, 32'h0, 32'h0);

        // Write every register, then read all addresses on both ports
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(1'b1, ADDR_W'(i), pat(i), 5'd0, 5'd0);
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 32'h0, ADDR_W'(i), ADDR_W'(31 - i));
            expect_rd("read_all", pat(i), pat(31 - i), pat(i), pat(31 - i));
        end

        // Zero register: writes discarded, never bypassed
        @(negedge clk);
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        expect_rd("r0_before_edge", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd1);
        expect_rd("r0_after_edge", 32'h0, pat(1), 32'h0, pat(1));

        // Bypass versus stored value on a same-address read/write
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h1111_1111, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd7);
        expect_rd("same_addr_before_edge", 32'h2222_2222, 32'h2222_2222,
                  32'h1111_1111, 32'h1111_1111);
        @(negedge clk);
        drive(1'b0, 5'd7, 32'h3333_3333, 5'd7, 5'd7);
        expect_rd("same_addr_after_edge", 32'h2222_2222, 32'h2222_2222,
                  32'h2222_2222, 32'h2222_2222);

        // Write disabled keeps the prior value
        @(negedge clk);
        drive(1'b0, 5'd9, 32'hABCD_0123, 5'd9, 5'd9);
        expect_rd("we0_before_edge", pat(9), pat(9), pat(9), pat(9));
        @(negedge clk);
        expect_rd("we0_after_edge", pat(9), pat(9), pat(9), pat(9));

        // Same again from reset: r9 stays 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd9, 32'hABCD_0123, 5'd9, 5'd31);
        expect_rd("we0_reset_before_edge", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        expect_rd("we0_reset_after_edge", 32'h0, 32'h0, 32'h0, 32'h0);

        // Drain the scoreboard with a bounded wait
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
            #1;
        end
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
